board_line_clear: RTL and testbench

Line-clear engine directly downstream of `board_save`. On a `start` pulse it snapshots the 200-bit board, scans rows bottom to top, and removes every full row. It then compacts the remaining rows downward and zero-fills the top by issuing row writes through the `board_save` request/response handshake. It reports the number of cleared rows and, optionally, a running score.

---
 rtl/tetris_pkg.sv | 37 +++
 rtl/row_full_detect.sv | 11 +
 rtl/board_line_clear.sv | 155 +++++++++++++++
 tb/tb_board_line_clear.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, line-clear FSM states and score table
package tetris_pkg;

  localparam int ROWS  = 20;
  localparam int COLS  = 10;
  localparam int IDX_W = 6;
  localparam int CNT_W = 5;

  localparam logic [IDX_W-1:0] ROWS_IDX = IDX_W'(ROWS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ROWS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SAVE_REQ,
    ST_SAVE_WAIT,
    ST_FILL,
    ST_DONE
  } state_t;

  localparam logic [15:0] SCORE_1 = 16'd40;
  localparam logic [15:0] SCORE_2 = 16'd100;
  localparam logic [15:0] SCORE_3 = 16'd300;
  localparam logic [15:0] SCORE_4 = 16'd1200;

  // Four or more rows in one pass all earn the top award.
  function automatic logic [15:0] score_for(input logic [CNT_W-1:0] n);
    case (n)
      5'd0:    score_for = 16'd0;
      5'd1:    score_for = SCORE_1;
      5'd2:    score_for = SCORE_2;
      5'd3:    score_for = SCORE_3;
      default: score_for = SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// rtl/row_full_detect.sv - flags a row whose every column is occupied
module row_full_detect
  import tetris_pkg::*;
(
  input  logic [COLS-1:0] row,
  output logic            full
);

  assign full = &row;

endmodule

// File: rtl/board_line_clear.sv
// rtl/board_line_clear.sv - removes full rows, compacts and zero-fills via board_save writes
// Optional running score is built only when LINE_CLEAR_SCORE_EN is defined.
module board_line_clear
  import tetris_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] board,
  input  logic                 ready_from_board,
  input  logic                 resp_from_board,
  output logic                 req_save_to_board,
  output logic                 req_analy_to_board,
  output logic [IDX_W-1:0]     row_idx,
  output logic [COLS-1:0]      row_info,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     lines_cleared,
  output logic [15:0]          score
);

  state_t           state, state_nxt;
  logic [COLS-1:0]  snap [ROWS];
  logic [IDX_W-1:0] rd, wr;
  logic [CNT_W-1:0] cnt;
  logic             from_scan;
  logic [COLS-1:0]  cur_row;
  logic             cur_full;
  logic             scan_end, fill_end;
  logic             busy_nxt, req_save_nxt, req_analy_nxt, done_nxt;

  assign scan_end = (rd == ROWS_IDX);
  assign fill_end = (wr == ROWS_IDX);

  always_comb begin
    cur_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rd == IDX_W'(r)) cur_row = snap[r];
    end
  end

  row_full_detect u_row_full (
    .row  (cur_row),
    .full (cur_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (scan_end)                  state_nxt = (cnt != '0) ? ST_FILL : ST_DONE;
        else if (!cur_full && wr != rd) state_nxt = ST_SAVE_REQ;
      end
      ST_SAVE_REQ:  if (resp_from_board) state_nxt = ST_SAVE_WAIT;
      ST_SAVE_WAIT: if (ready_from_board) state_nxt = from_scan ? ST_SCAN : ST_FILL;
      ST_FILL:      state_nxt = fill_end ? ST_DONE : ST_SAVE_REQ;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it.
  always_comb begin
    busy_nxt      = (state_nxt == ST_SCAN) || (state_nxt == ST_SAVE_REQ) ||
                    (state_nxt == ST_SAVE_WAIT) || (state_nxt == ST_FILL);
    req_save_nxt  = (state_nxt == ST_SAVE_REQ);
    req_analy_nxt = (state_nxt == ST_SCAN);
    done_nxt      = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy               <= 1'b0;
      req_save_to_board  <= 1'b0;
      req_analy_to_board <= 1'b0;
      done               <= 1'b0;
      lines_cleared      <= '0;
    end else begin
      busy               <= busy_nxt;
      req_save_to_board  <= req_save_nxt;
      req_analy_to_board <= req_analy_nxt;
      done               <= done_nxt;
      if (state == ST_IDLE && start) lines_cleared <= '0;
      else if (done_nxt)             lines_cleared <= cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) snap[r] <= '0;
      rd        <= '0;
      wr        <= '0;
      cnt       <= '0;
      from_scan <= 1'b0;
      row_idx   <= '0;
      row_info  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int r = 0; r < ROWS; r++) snap[r] <= board[r*COLS +: COLS];
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
          end
        end
        ST_SCAN: begin
          if (!scan_end) begin
            if (cur_full) begin
              cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
              rd  <= rd + 1'b1;
            end else if (wr == rd) begin
              wr <= wr + 1'b1;
              rd <= rd + 1'b1;
            end else begin
              row_idx   <= wr;
              row_info  <= cur_row;
              from_scan <= 1'b1;
            end
          end
        end
        ST_SAVE_WAIT: begin
          if (ready_from_board) begin
            wr <= wr + 1'b1;
            if (from_scan) rd <= rd + 1'b1;
          end
        end
        ST_FILL: begin
          if (!fill_end) begin
            row_idx   <= wr;
            row_info  <= '0;
            from_scan <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        score <= '0;
    else if (done_nxt) score <= score + score_for(cnt);
  end
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_board_line_clear.sv
// tb/tb_board_line_clear.sv - directed bench for board_line_clear with a board_save responder model
module tb_board_line_clear;
  import tetris_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [ROWS*COLS-1:0] board = '0;
  logic                 ready_from_board = 1'b1;
  logic                 resp_from_board = 1'b0;
  logic                 req_save_to_board;
  logic                 req_analy_to_board;
  logic [IDX_W-1:0]     row_idx;
  logic [COLS-1:0]      row_info;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     lines_cleared;
  logic [15:0]          score;

  int n_tests = 0;
  int n_fail  = 0;

  int resp_delay = 0;
  int hold = 0;
  int n_writes = 0;
  int stable_err = 0;
  int overlap_err = 0;
  int range_err = 0;
  logic [IDX_W-1:0] cap_idx, first_idx;
  logic [COLS-1:0]  cap_info, first_info;
  logic [COLS-1:0]  mem [ROWS];
  logic [15:0]      exp_score = '0;

  always #5 clk = ~clk;

  board_line_clear dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .board              (board),
    .ready_from_board   (ready_from_board),
    .resp_from_board    (resp_from_board),
    .req_save_to_board  (req_save_to_board),
    .req_analy_to_board (req_analy_to_board),
    .row_idx            (row_idx),
    .row_info           (row_info),
    .busy               (busy),
    .done               (done),
    .lines_cleared      (lines_cleared),
    .score              (score)
  );

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [199:0] pack_mem();
    logic [199:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) v[r*COLS +: COLS] = mem[r];
    return v;
  endfunction

  // board_save responder: resp after resp_delay extra cycles, then one busy cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      resp_from_board  = 1'b0;
      ready_from_board = 1'b1;
      hold = 0;
    end else begin
      if (req_save_to_board && req_analy_to_board) overlap_err++;
      if (resp_from_board) begin
        resp_from_board  = 1'b0;
        ready_from_board = 1'b0;
      end else if (!ready_from_board) begin
        ready_from_board = 1'b1;
      end else if (req_save_to_board) begin
        if (hold == 0) begin
          cap_idx  = row_idx;
          cap_info = row_info;
        end else if (row_idx !== cap_idx || row_info !== cap_info) begin
          stable_err++;
        end
        if (hold >= resp_delay) begin
          resp_from_board = 1'b1;
          hold = 0;
          if (n_writes == 0) begin
            first_idx  = row_idx;
            first_info = row_info;
          end
          n_writes++;
          if (row_idx < IDX_W'(ROWS)) mem[row_idx[4:0]] = row_info;
          else range_err++;
        end else begin
          hold++;
        end
      end
    end
  end

  task automatic load_board(input logic [199:0] b, input int delay);
    board = b;
    for (int r = 0; r < ROWS; r++) mem[r] = b[r*COLS +: COLS];
    n_writes   = 0;
    resp_delay = delay;
  endtask

  task automatic run_pass(input string name, input logic [199:0] b, input int delay,
                          input bit inject, input int exp_writes,
                          input logic [IDX_W-1:0] exp_fidx, input logic [COLS-1:0] exp_finfo,
                          input logic [199:0] exp_mem, input logic [CNT_W-1:0] exp_lines,
                          input logic [15:0] score_inc, input int exp_lat);
    int cyc;
    bit seen;
    logic [15:0] inc_eff;
    inc_eff = score_inc;
`ifndef LINE_CLEAR_SCORE_EN
    inc_eff = '0;
`endif
    load_board(b, delay);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == 1) begin
        check({name, "_busy"}, busy, 1'b1);
        check({name, "_analy"}, req_analy_to_board, 1'b1);
      end
      if (inject && cyc == 10) start = 1'b1;
      else start = 1'b0;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({name, "_done_seen"}, seen, 1'b1);
    if (exp_lat > 0) check({name, "_latency"}, cyc, exp_lat);
    exp_score = exp_score + inc_eff;
    check({name, "_lines"}, lines_cleared, exp_lines);
    check({name, "_score"}, score, exp_score);
    check({name, "_writes"}, n_writes, exp_writes);
    if (exp_writes > 0) begin
      check({name, "_first_idx"}, first_idx, exp_fidx);
      check({name, "_first_info"}, first_info, exp_finfo);
    end
    check({name, "_board"}, pack_mem(), exp_mem);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_idle_after"}, {busy, done, req_save_to_board, req_analy_to_board}, 4'b0000);
  endtask

  logic [199:0] b;
  logic [199:0] full_b;
  int           cyc;

  initial begin
    full_b = '1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, req_save_to_board, req_analy_to_board,
                            row_idx, row_info, lines_cleared, score}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // No full rows: row r holds r+1.
    b = '0;
    for (int r = 0; r < ROWS; r++) b[r*COLS +: COLS] = COLS'(r + 1);
    run_pass("nofull", b, 0, 1'b0, 0, '0, '0, b, 5'd0, 16'd0, 21);

    // One full row at the bottom.
    b = '0;
    b[9:0]   = 10'h3FF;
    b[19:10] = 10'h155;
    run_pass("one", b, 0, 1'b0, 20, 6'd0, 10'h155, 200'h155, 5'd1, 16'd40, 0);

    // Four full rows under a partial row.
    b = '0;
    for (int r = 0; r < 4; r++) b[r*COLS +: COLS] = 10'h3FF;
    b[49:40] = 10'h0F0;
    run_pass("four", b, 0, 1'b0, 20, 6'd0, 10'h0F0, 200'h0F0, 5'd4, 16'd1200, 0);

    // Whole board full.
    run_pass("all", full_b, 0, 1'b0, 20, 6'd0, 10'h000, 200'h0, 5'd20, 16'd1200, 0);

    // Interleaved full rows, slow responder, ignored mid-pass start.
    b = '0;
    b[9:0]   = 10'h3FF;
    b[19:10] = 10'h001;
    b[29:20] = 10'h3FF;
    b[39:30] = 10'h200;
    run_pass("slow", b, 3, 1'b1, 20, 6'd0, 10'h001, 200'h80001, 5'd2, 16'd100, 0);
    check("req_stable", stable_err, 0);
    check("req_exclusive", overlap_err, 0);
    check("row_range", range_err, 0);

    // Reset while zero-filling.
    load_board(full_b, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (n_writes < 3 && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("rst_reach_fill", n_writes >= 3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_fill_outputs", {busy, done, req_save_to_board, req_analy_to_board,
                               row_idx, row_info, lines_cleared, score}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_score = '0;
    b = '0;
    b[9:0]   = 10'h3FF;
    b[19:10] = 10'h155;
    run_pass("after_rst", b, 0, 1'b0, 20, 6'd0, 10'h155, 200'h155, 5'd1, 16'd40, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
